// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue of NREQ requesters onto one 2-stage ALU with tagged responses
// Optional: ALU_PERF_CNT_EN adds issue/stall performance counters.
module alu_issue_arbiter #(
    parameter int          NREQ    = 4,
    parameter int          IDW     = 2,
    parameter logic [15:0] NOP_INS = 16'hF000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_pc,
    input  logic [NREQ*16-1:0]   req_ins,
    input  logic [NREQ*16-1:0]   req_op1,
    input  logic [NREQ*16-1:0]   req_op2,
    input  logic                 hold,
    input  logic                 flush,
    output logic [15:0]          alu_pc,
    output logic [15:0]          alu_ins,
    output logic [15:0]          alu_op1,
    output logic [15:0]          alu_op2,
    input  logic [15:0]          alu_result,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 busy
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic           grant_en;
    logic [IDW-1:0] ptr_next;
    logic           s1_valid;
    logic           s2_valid;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] s2_id;

    // First pending requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W)
                cand = cand - NREQ_W;
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    assign grant_en = grant_any && !hold && !flush && rst_n;
    assign ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        alu_pc    = 16'h0000;
        alu_ins   = NOP_INS;
        alu_op1   = 16'h0000;
        alu_op2   = 16'h0000;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_en && (grant_idx == IDW'(i));
            if (grant_en && (grant_idx == IDW'(i))) begin
                alu_pc  = req_pc[16*i +: 16];
                alu_ins = req_ins[16*i +: 16];
                alu_op1 = req_op1[16*i +: 16];
                alu_op2 = req_op2[16*i +: 16];
            end
        end
    end

    // Tags mirror the ALU's execute-1/execute-2 stages; flush kills both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_id    <= '0;
            s2_id    <= '0;
        end else begin
            if (grant_en)
                ptr <= ptr_next;
            s1_valid <= grant_en;
            s1_id    <= grant_idx;
            s2_valid <= s1_valid && !flush;
            s2_id    <= s1_id;
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_id     = s2_id;
    assign rsp_result = alu_result;
    assign busy       = s1_valid || s2_valid;

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (grant_en)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            else if (|req_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter with a 2-stage ALU model
module tb_alu_issue_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    res;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*16-1:0] req_pc, req_ins, req_op1, req_op2;
    logic            hold, flush;
    logic [15:0]     alu_pc, alu_ins, alu_op1, alu_op2, alu_result;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [15:0]     rsp_result;
    logic            busy;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]     perf_issue_cnt, perf_stall_cnt;
    int              m_issue = 0;
    int              m_stall = 0;
`endif

    logic [15:0] pc [NREQ];
    logic [15:0] ins[NREQ];
    logic [15:0] op1[NREQ];
    logic [15:0] op2[NREQ];
    logic [NREQ-1:0] pend;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   m_ptr = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .NOP_INS(16'hF000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_ins(req_ins), .req_op1(req_op1), .req_op2(req_op2),
        .hold(hold), .flush(flush),
        .alu_pc(alu_pc), .alu_ins(alu_ins), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
`ifdef ALU_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_pc[16*i +: 16]  = pc[i];
            req_ins[16*i +: 16] = ins[i];
            req_op1[16*i +: 16] = op1[i];
            req_op2[16*i +: 16] = op2[i];
        end
    end

    function automatic logic [15:0] alu_fn(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
        case (i[15:12])
            4'h0:    return a + b;
            4'h1:    return a - b;
            default: return 16'h0000;
        endcase
    endfunction

    // Two-stage ALU: result of the op presented in cycle T is visible in T+2.
    logic [15:0] x1 = 16'h0000;
    logic [15:0] x2 = 16'h0000;
    always @(posedge clk) begin
        x1 <= alu_fn(alu_ins, alu_op1, alu_op2);
        x2 <= x1;
    end
    assign alu_result = x2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_fields();
        logic [3:0] opc;
        for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 2))
                0:       opc = 4'h0;
                1:       opc = 4'h1;
                default: opc = 4'hF;
            endcase
            pc[i]  = 16'($urandom);
            ins[i] = {opc, 12'($urandom)};
            op1[i] = 16'($urandom);
            op2[i] = 16'($urandom);
        end
    endtask

    // One clock cycle: predict, compare mid-cycle, then advance the model at the edge.
    task automatic step();
        int         g;
        int         c;
        logic       gnt;
        logic [3:0] er;
        exp_t       e;
        req_valid = pend;
        #2;
        gnt = 1'b0;
        g   = 0;
        er  = 4'b0000;
        if (pend != 0 && !hold && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!gnt && pend[c]) begin
                    gnt = 1'b1;
                    g   = c;
                end
            end
        end
        if (gnt)
            er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        if (gnt) begin
            check("alu_pc", 32'(alu_pc), 32'(pc[g]));
            check("alu_ins", 32'(alu_ins), 32'(ins[g]));
            check("alu_op1", 32'(alu_op1), 32'(op1[g]));
            check("alu_op2", 32'(alu_op2), 32'(op2[g]));
        end else begin
            check("alu_nop", 32'(alu_ins), 32'h0000F000);
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_s2));
        if (m_s2) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_result", 32'(rsp_result), 32'(e.res));
            end
        end
        check("busy", 32'(busy), 32'(m_s1 | m_s2));
        if (gnt) begin
            e.id  = IDW'(g);
            e.res = alu_fn(ins[g], op1[g], op2[g]);
            sb.push_back(e);
        end
`ifdef ALU_PERF_CNT_EN
        if (gnt) m_issue++;
        else if (pend != 0) m_stall++;
`endif
        @(posedge clk);
        if (flush) begin
            if (m_s1) void'(sb.pop_back());
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = gnt;
        end
        if (gnt) begin
            m_ptr   = (g + 1) % NREQ;
            pend[g] = 1'b0;
        end
        #1;
        rand_fields();
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        rand_fields();
        pend      = 4'hF;
        req_valid = pend;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend  = 4'b0000;

        // single request round trip: 3 + 4 = 7 from requester 1
        pend = 4'b0010; ins[1] = 16'h0000; op1[1] = 16'd3; op2[1] = 16'd4;
        step();
        pend = 4'b0000;
        repeat (3) step();

        // pointer wrap: grant 3, then 0 and 2 pending -> 0 then 2
        pend = 4'b1000; step();
        pend = 4'b0101; step(); step();
        pend = 4'b1000; step();

        // round-robin rotation with all requesters continuously pending
        repeat (8) begin
            pend = 4'hF;
            step();
        end
        pend = 4'b0000;
        repeat (2) step();

        // hold with an op issued just before
        pend = 4'b0001; step();
        hold = 1'b1; pend = 4'b0100;
        repeat (3) step();
        hold = 1'b0; step();
        repeat (2) step();

        // flush: grants in T and T+1, flush in T+2, pending request granted T+3
        pend = 4'b0111; step(); step();
        flush = 1'b1; step();
        flush = 1'b0; step();
        repeat (3) step();

        // async reset with two ops in flight
        pend = 4'hF; step(); step();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        m_ptr = 0; m_s1 = 1'b0; m_s2 = 1'b0;
`ifdef ALU_PERF_CNT_EN
        m_issue = 0; m_stall = 0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend  = 4'b1010;
        step(); step();

        // random traffic with hold and flush, including both together
        repeat (60) begin
            pend  = pend | 4'($urandom_range(0, 15));
            hold  = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            step();
        end
        hold = 1'b0; flush = 1'b0; pend = 4'b0000;
        repeat (4) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef ALU_PERF_CNT_EN
        check("perf_issue", perf_issue_cnt, 32'(m_issue));
        check("perf_stall", perf_stall_cnt, 32'(m_stall));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one two-stage ALU pipeline (execute-1 / execute-2, fixed 2-cycle latency, no enable or stall input) between NREQ requesters, e.g. per-lane decode stages in the parallel core.
- Round-robin arbitration selects at most one request per cycle and drives it onto the ALU's fr_* inputs.
- A 2-deep tag shift register tracks in-flight requester ids. Each ALU x2_result is returned to its originator with that id.
- Also provides hold and flush control for jumps and memory stalls.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must be >= clog2(NREQ).
- NOP_INS, 16'hF000, instruction driven to the ALU when nothing is issued (opcode 1111, ALU result 0).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  grant; one-hot or zero; handshake completes when valid&ready.
- req_pc  in  NREQ*16  packed pc, requester i at [16i+15:16i].
- req_ins  in  NREQ*16  packed instruction.
- req_op1  in  NREQ*16  packed operand 1.
- req_op2  in  NREQ*16  packed operand 2.
- hold  in  1  suppress new grants this cycle.
- flush  in  1  kill all in-flight ops and suppress grants this cycle.
- alu_pc  out  16  to ALU fr_pc.
- alu_ins  out  16  to ALU fr_ins.
- alu_op1  out  16  to ALU fr_operand_1.
- alu_op2  out  16  to ALU fr_operand_2.
- alu_result  in  16  from ALU x2_result.
- rsp_valid  out  1  response valid, one cycle.
- rsp_id  out  IDW  requester that owns the response.
- rsp_result  out  16  result value, equal to alu_result.
- busy  out  1  any op in flight (s1_valid|s2_valid).

Behaviour:
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending with wrap at NREQ-1 -> 0. The first set bit is the grant.
  - req_ready = onehot(grant) when any req_valid && !hold && !flush && rst_n; otherwise 0.
  - req_ready never asserts for a requester whose req_valid is low.
- Issue mux (combinational):
  - When a grant exists, alu_pc/ins/op1/op2 = the granted requester's fields.
  - Otherwise alu_ins = NOP_INS and alu_pc = alu_op1 = alu_op2 = 0.
  - No bubble: a grant in every cycle is legal.
- Pointer update:
  - On a grant of index g, ptr <= (g+1) mod NREQ.
  - With no grant, ptr holds.
  - Reset value 0.
- Tag pipeline:
  - Stage 1: s1_valid <= grant_any; s1_id <= g.
  - Stage 2: s2_valid <= s1_valid; s2_id <= s1_id.
  - Op granted in cycle T: ALU captures at end of T, x2_result is valid during T+2.
- Response (combinational from stage 2):
  - rsp_valid = s2_valid; rsp_id = s2_id; rsp_result = alu_result.
  - No response backpressure; requesters must accept.
- Flush:
  - At the edge where flush=1: s1_valid <= 0 and s2_valid <= 0.
  - rsp_valid in the flush cycle itself still reflects the pre-flush s2_valid.
  - A request presented during flush is not granted and stays pending.
  - ptr is unchanged by flush.
- Hold: blocks grants only; in-flight ops drain and respond normally.
- hold and flush both asserted: flush semantics apply.
- Reset (async, rst_n=0):
  - Immediately: ptr=0, s1/s2_valid=0, s1/s2_id=0, rsp_valid=0, busy=0, req_ready=0.
  - In-flight ops are dropped.
  - Requesters re-present after reset release.
- Ordering: responses return in grant order; at most 2 in flight.

Optional Feature:
- Macro: ALU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_issue_cnt (32) and perf_stall_cnt (32), both reset to 0 asynchronously.
  - perf_issue_cnt increments on each grant.
  - perf_stall_cnt increments in each cycle where any req_valid=1 and no grant is given (hold or flush).
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan (NREQ=4):
- Single request, round trip:
  - Stimulus: req 1 only in cycle T, ins=16'h0000 (add), op1=3, op2=4.
  - Required: req_ready=4'b0010 in T; rsp_valid=1, rsp_id=1, rsp_result=7 in T+2; busy=1 in T+1..T+2.
- Round-robin rotation:
  - Stimulus: all four req_valid held high for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical, delayed 2 cycles; rsp_valid continuously high from T+2.
- Pointer wrap:
  - Stimulus: grant index 3, then req 0 and req 2 both valid.
  - Required: grant 0 next (ptr=0), then grant 2.
- Hold:
  - Stimulus: hold=1 for 3 cycles with req 2 valid, an op issued one cycle before hold.
  - Required: no grants during hold; the earlier op still responds; req 2 granted the cycle hold drops; alu_ins=16'hF000 while holding.
- Flush:
  - Stimulus: grants in T and T+1, flush in T+2.
  - Required: rsp for the T grant still seen in T+2; the T+1 grant never responds (rsp_valid=0 in T+3); a pending request is not granted in T+2 and is granted in T+3.
- Async reset mid-operation:
  - Stimulus: rst_n low between clock edges with 2 ops in flight.
  - Required: rsp_valid, busy and req_ready go to 0 immediately; after release, the first grant goes to the lowest valid index (ptr=0).
